// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier that retires two multiplier bits per clock.
// Computes the full 2*WIDTH-bit product, signed x signed or unsigned x unsigned per operation.
module seq_booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // state | meaning
  // IDLE  | waiting for start; ready high
  // CALC  | one Booth digit retired per clock, ITER clocks total
  // DONE  | product valid, done pulses for this single cycle
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam int QW   = WIDTH + 2;
  localparam int AW   = WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [QW-1:0]   m;
  logic [QW-1:0]   q;
  logic            q_m1;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   m_x;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   acc_nxt;
  logic [QW-1:0]   q_nxt;
  logic [QW-1:0]   a_ext;
  logic [QW-1:0]   b_ext;

  always_comb begin
    a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  end

  // Booth digit selects 0, +-M or +-2M; the sum is then shifted right by two
  // as one {acc, q} pair, so q doubles as the product's low-order bits.
  always_comb begin
    m_x = {{2{m[QW-1]}}, m};
    pp  = '0;
    unique case ({q[1:0], q_m1})
      3'b001, 3'b010: pp = m_x;
      3'b011:         pp = m_x << 1;
      3'b100:         pp = -(m_x << 1);
      3'b101, 3'b110: pp = -m_x;
      default:        pp = '0;
    endcase
    acc_sum = acc + pp;
    acc_nxt = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    q_nxt   = {acc_sum[1:0], q[QW-1:2]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && ready) begin
            m     <= a_ext;
            q     <= b_ext;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          q_m1 <= q[1];
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            // After ITER steps all QW multiplier bits have shifted out of q,
            // so the low 2*WIDTH bits of {acc, q} are the exact product.
            product <= {acc_nxt[WIDTH-3:0], q_nxt};
            done    <= 1'b1;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
